// File: rtl/redmule_clk_en_ctrl_if.sv
// Control-side bundle of the RedMulE clock-enable controller: system enables and
// activity in, per-domain gate enables and status out.
interface redmule_clk_en_ctrl_if #(
    parameter int unsigned N_DOMAINS  = 2,
    parameter int unsigned IDLE_CNT_W = 8
);
    logic                  test_mode;
    logic [N_DOMAINS-1:0]  fetch_enable;
    logic [N_DOMAINS-1:0]  busy;
    logic [N_DOMAINS-1:0]  wake_req;
    logic [IDLE_CNT_W-1:0] idle_thr;
    logic [N_DOMAINS-1:0]  clk_en;
    logic [N_DOMAINS-1:0]  ready;
    logic [N_DOMAINS-1:0]  sleep;

    // System control / activity source
    modport master (
        output test_mode, fetch_enable, busy, wake_req, idle_thr,
        input  clk_en, ready, sleep
    );

    // Clock-enable controller
    modport slave (
        input  test_mode, fetch_enable, busy, wake_req, idle_thr,
        output clk_en, ready, sleep
    );
endinterface

// File: rtl/redmule_clk_en_ctrl.sv
// Per-domain clock-enable controller for RedMulE: OFF/WAKE/ON/SLEEP FSM per domain with
// idle-based auto-gating, wake-on-request and a settle delay before ready.
module redmule_clk_en_dom #(
    parameter int unsigned IDLE_CNT_W = 8,
    parameter int unsigned WAKE_LAT   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fetch_en_i,
    input  logic                  busy_i,
    input  logic                  wake_req_i,
    input  logic [IDLE_CNT_W-1:0] idle_thr_i,
    output logic                  clk_en_o,
    output logic                  ready_o,
    output logic                  sleep_o
);
    typedef enum logic [1:0] {ST_OFF, ST_WAKE, ST_ON, ST_SLEEP} state_e;

    localparam int unsigned SETTLE_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(WAKE_LAT - 1);

    state_e                state_q, state_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  clk_en_q, clk_en_d;
    logic                  ready_q, ready_d;
    logic                  sleep_q, sleep_d;

    logic                  active;
    logic [IDLE_CNT_W:0]   idle_inc;

    always_comb begin
        active     = busy_i | wake_req_i;
        // One extra bit so the threshold compare still works once the count saturates
        idle_inc   = {1'b0, idle_cnt_q} + {{IDLE_CNT_W{1'b0}}, 1'b1};
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        settle_d   = settle_q;

        if (!fetch_en_i) begin
            state_d    = ST_OFF;
            idle_cnt_d = '0;
            settle_d   = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d  = ST_WAKE;
                    settle_d = '0;
                end
                ST_WAKE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d    = ST_ON;
                        idle_cnt_d = '0;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end
                ST_ON: begin
                    if (active) begin
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_inc[IDLE_CNT_W] ? '1 : idle_inc[IDLE_CNT_W-1:0];
                        if ((idle_thr_i != '0) && (idle_inc >= {1'b0, idle_thr_i}))
                            state_d = ST_SLEEP;
                    end
                end
                ST_SLEEP: begin
                    if (active) begin
                        state_d    = ST_WAKE;
                        idle_cnt_d = '0;
                        settle_d   = '0;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        // Outputs follow the next state so they are flops, not decodes of state_q
        clk_en_d = (state_d == ST_WAKE) || (state_d == ST_ON);
        ready_d  = (state_d == ST_ON);
        sleep_d  = (state_d == ST_SLEEP);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_OFF;
            idle_cnt_q <= '0;
            settle_q   <= '0;
            clk_en_q   <= 1'b0;
            ready_q    <= 1'b0;
            sleep_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            settle_q   <= settle_d;
            clk_en_q   <= clk_en_d;
            ready_q    <= ready_d;
            sleep_q    <= sleep_d;
        end
    end

    assign clk_en_o = clk_en_q;
    assign ready_o  = ready_q;
    assign sleep_o  = sleep_q;
endmodule

module redmule_clk_en_ctrl #(
    parameter int unsigned N_DOMAINS  = 2,
    parameter int unsigned IDLE_CNT_W = 8,
    parameter int unsigned WAKE_LAT   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    redmule_clk_en_ctrl_if.slave  ctrl
);
    logic [N_DOMAINS-1:0] fsm_en;
    logic [N_DOMAINS-1:0] ready_v;
    logic [N_DOMAINS-1:0] sleep_v;

    for (genvar d = 0; d < N_DOMAINS; d++) begin : g_dom
        redmule_clk_en_dom #(
            .IDLE_CNT_W (IDLE_CNT_W),
            .WAKE_LAT   (WAKE_LAT)
        ) u_dom (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .fetch_en_i (ctrl.fetch_enable[d]),
            .busy_i     (ctrl.busy[d]),
            .wake_req_i (ctrl.wake_req[d]),
            .idle_thr_i (ctrl.idle_thr),
            .clk_en_o   (fsm_en[d]),
            .ready_o    (ready_v[d]),
            .sleep_o    (sleep_v[d])
        );
    end

    // test_mode bypasses the flops so scan can run the gated clocks straight out of reset
    assign ctrl.clk_en = fsm_en | {N_DOMAINS{ctrl.test_mode}};
    assign ctrl.ready  = ready_v;
    assign ctrl.sleep  = sleep_v;

`ifndef SYNTHESIS
    a_ready_has_clk: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ready_v & ~fsm_en) == '0);
    a_sleep_not_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (sleep_v & ready_v) == '0);
`endif
endmodule

// File: tb/tb_redmule_clk_en_ctrl.sv
// Self-checking bench for redmule_clk_en_ctrl: directed scenarios plus randomized traffic,
// all checked against a per-domain behavioural model.
module tb_redmule_clk_en_ctrl;
    localparam int ND = 2;
    localparam int IW = 8;
    localparam int WL = 2;
    localparam int CNT_MAX = (1 << IW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails = 0;

    redmule_clk_en_ctrl_if #(.N_DOMAINS(ND), .IDLE_CNT_W(IW)) ifc ();

    redmule_clk_en_ctrl #(.N_DOMAINS(ND), .IDLE_CNT_W(IW), .WAKE_LAT(WL)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ctrl   (ifc)
    );

    always #5 clk = ~clk;

    // Behavioural model: domain mode, remaining settle cycles, consecutive idle cycles
    typedef enum {M_OFF, M_WAKING, M_RUN, M_ASLEEP} mode_e;
    mode_e mode[ND];
    int    wake_left[ND];
    int    idle_run[ND];
    logic [ND-1:0] exp_en, exp_rdy, exp_slp;

    task automatic model_step();
        for (int d = 0; d < ND; d++) begin
            bit act;
            act = ifc.busy[d] | ifc.wake_req[d];
            if (!rst_n || !ifc.fetch_enable[d]) begin
                mode[d] = M_OFF;
                idle_run[d] = 0;
            end else begin
                case (mode[d])
                    M_OFF: begin
                        mode[d] = M_WAKING;
                        wake_left[d] = WL;
                    end
                    M_WAKING: begin
                        wake_left[d]--;
                        if (wake_left[d] == 0) begin
                            mode[d] = M_RUN;
                            idle_run[d] = 0;
                        end
                    end
                    M_RUN: begin
                        if (act) idle_run[d] = 0;
                        else begin
                            if (ifc.idle_thr != 0 && idle_run[d] + 1 >= int'(ifc.idle_thr))
                                mode[d] = M_ASLEEP;
                            idle_run[d] = (idle_run[d] + 1 > CNT_MAX) ? CNT_MAX : idle_run[d] + 1;
                        end
                    end
                    M_ASLEEP: begin
                        if (act) begin
                            mode[d] = M_WAKING;
                            wake_left[d] = WL;
                            idle_run[d] = 0;
                        end
                    end
                    default: mode[d] = M_OFF;
                endcase
            end
        end
    endtask

    task automatic model_outputs();
        for (int d = 0; d < ND; d++) begin
            exp_en[d]  = (mode[d] == M_WAKING || mode[d] == M_RUN) || ifc.test_mode;
            exp_rdy[d] = (mode[d] == M_RUN);
            exp_slp[d] = (mode[d] == M_ASLEEP);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_outputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.test_mode = 1'b0;
        ifc.fetch_enable = 2'b11;
        ifc.busy = 2'b11;
        ifc.wake_req = 2'b10;
        ifc.idle_thr = 8'd0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({ifc.clk_en, ifc.ready, ifc.sleep} !== 6'b0) begin
            fails++;
            $display("FAIL reset: en=%b rdy=%b slp=%b required all 0", ifc.clk_en, ifc.ready, ifc.sleep);
        end
    endtask

    task automatic test_wake_latency();
        ifc.fetch_enable = 2'b00;
        ifc.busy = 2'b00;
        ifc.wake_req = 2'b00;
        rst_n = 1'b1;
        tick();
        ifc.fetch_enable = 2'b01;
        tick();
        checks++;
        if (ifc.clk_en !== 2'b01 || ifc.ready !== 2'b00) begin
            fails++;
            $display("FAIL wake_edge1: en=%b rdy=%b required en=01 rdy=00", ifc.clk_en, ifc.ready);
        end
        tick();
        checks++;
        if (ifc.ready !== 2'b00) begin
            fails++;
            $display("FAIL wake_edge2: rdy=%b required 00", ifc.ready);
        end
        tick();
        checks++;
        if (ifc.clk_en !== 2'b01 || ifc.ready !== 2'b01 || ifc.sleep !== 2'b00) begin
            fails++;
            $display("FAIL wake_ready: en=%b rdy=%b slp=%b required 01 01 00", ifc.clk_en, ifc.ready, ifc.sleep);
        end
    endtask

    task automatic test_idle_gating();
        ifc.busy = 2'b01;
        tick();
        ifc.busy = 2'b00;
        ifc.idle_thr = 8'd4;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (ifc.clk_en[0] !== (i < 4) || ifc.sleep[0] !== (i == 4)) begin
                fails++;
                $display("FAIL idle_gate cyc%0d: en=%b slp=%b required en=%b", i, ifc.clk_en[0], ifc.sleep[0], i < 4);
            end
        end
        ifc.busy = 2'b01;
        tick();
        ifc.busy = 2'b00;
        tick();
        tick();
        tick();
        tick();
        ifc.busy = 2'b01;
        tick();
        ifc.busy = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (ifc.clk_en[0] !== (i < 4) || ifc.sleep[0] !== (i == 4) ||
                {ifc.clk_en, ifc.ready, ifc.sleep} !== {exp_en, exp_rdy, exp_slp}) begin
                fails++;
                $display("FAIL idle_busy_pulse cyc%0d: en=%b rdy=%b slp=%b required %b %b %b",
                         i, ifc.clk_en, ifc.ready, ifc.sleep, exp_en, exp_rdy, exp_slp);
            end
        end
    endtask

    task automatic test_sleep_wake();
        ifc.wake_req = 2'b01;
        tick();
        ifc.wake_req = 2'b00;
        checks++;
        if (ifc.clk_en[0] !== 1'b1 || ifc.ready[0] !== 1'b0 || ifc.sleep[0] !== 1'b0) begin
            fails++;
            $display("FAIL sleep_wake_en: en=%b rdy=%b slp=%b required 1 0 0", ifc.clk_en[0], ifc.ready[0], ifc.sleep[0]);
        end
        ifc.idle_thr = 8'd0;
        tick();
        tick();
        checks++;
        if (ifc.ready[0] !== 1'b1 || {ifc.clk_en, ifc.ready, ifc.sleep} !== {exp_en, exp_rdy, exp_slp}) begin
            fails++;
            $display("FAIL sleep_wake_ready: en=%b rdy=%b slp=%b required %b %b %b",
                     ifc.clk_en, ifc.ready, ifc.sleep, exp_en, exp_rdy, exp_slp);
        end
    endtask

    task automatic test_thr_zero();
        int bad;
        bad = 0;
        ifc.idle_thr = 8'd0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (ifc.clk_en[0] !== 1'b1 || ifc.ready[0] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL thr_zero_hold: %0d cycles with en/rdy low, required 0", bad);
        end
        ifc.idle_thr = 8'd3;
        tick();
        checks++;
        if (ifc.clk_en[0] !== 1'b0 || ifc.sleep[0] !== 1'b1 || ifc.ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL thr_sat_gate: en=%b slp=%b rdy=%b required 0 1 0", ifc.clk_en[0], ifc.sleep[0], ifc.ready[0]);
        end
    endtask

    task automatic test_fetch_drop();
        ifc.idle_thr = 8'd0;
        ifc.fetch_enable = 2'b11;
        ifc.wake_req = 2'b01;
        tick();
        ifc.wake_req = 2'b00;
        ifc.fetch_enable = 2'b00;
        tick();
        checks++;
        if ({ifc.clk_en, ifc.ready, ifc.sleep} !== 6'b0) begin
            fails++;
            $display("FAIL drop_in_wake: en=%b rdy=%b slp=%b required all 0", ifc.clk_en, ifc.ready, ifc.sleep);
        end
        ifc.fetch_enable = 2'b01;
        tick();
        tick();
        ifc.fetch_enable = 2'b00;
        tick();
        ifc.fetch_enable = 2'b11;
        tick();
        tick();
        checks++;
        if (ifc.ready !== 2'b00 || ifc.clk_en !== 2'b11) begin
            fails++;
            $display("FAIL rewake_full_latency: en=%b rdy=%b required en=11 rdy=00", ifc.clk_en, ifc.ready);
        end
        tick();
        ifc.busy = 2'b11;
        tick();
        ifc.fetch_enable = 2'b10;
        tick();
        checks++;
        if (ifc.clk_en !== 2'b10 || ifc.ready !== 2'b10) begin
            fails++;
            $display("FAIL drop_while_busy: en=%b rdy=%b required en=10 rdy=10", ifc.clk_en, ifc.ready);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({ifc.clk_en, ifc.ready, ifc.sleep} !== 6'b0) begin
            fails++;
            $display("FAIL reset_mid_on: en=%b rdy=%b slp=%b required all 0", ifc.clk_en, ifc.ready, ifc.sleep);
        end
        rst_n = 1'b1;
        ifc.busy = 2'b00;
        ifc.fetch_enable = 2'b00;
        tick();
    endtask

    task automatic test_test_mode();
        ifc.test_mode = 1'b1;
        #1;
        model_outputs();
        checks++;
        if (ifc.clk_en !== 2'b11 || ifc.ready !== 2'b00) begin
            fails++;
            $display("FAIL tm_off: en=%b rdy=%b required en=11 rdy=00", ifc.clk_en, ifc.ready);
        end
        ifc.fetch_enable = 2'b01;
        ifc.idle_thr = 8'd1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (ifc.clk_en !== 2'b11 || ifc.ready !== 2'b00 || ifc.sleep !== 2'b01) begin
            fails++;
            $display("FAIL tm_sleep: en=%b rdy=%b slp=%b required 11 00 01", ifc.clk_en, ifc.ready, ifc.sleep);
        end
        ifc.test_mode = 1'b0;
        #1;
        model_outputs();
        checks++;
        if (ifc.clk_en !== 2'b00 || ifc.sleep !== 2'b01) begin
            fails++;
            $display("FAIL tm_release: en=%b slp=%b required en=00 slp=01", ifc.clk_en, ifc.sleep);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int d = 0; d < ND; d++) begin
                if ($urandom_range(0, 19) == 0) ifc.fetch_enable[d] = ~ifc.fetch_enable[d];
                ifc.busy[d]     = ($urandom_range(0, 5) == 0);
                ifc.wake_req[d] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 5))
                    0: ifc.idle_thr = 8'd0;
                    1: ifc.idle_thr = 8'd1;
                    2: ifc.idle_thr = 8'd2;
                    3: ifc.idle_thr = 8'd3;
                    4: ifc.idle_thr = 8'($urandom_range(4, 12));
                    default: ifc.idle_thr = 8'd255;
                endcase
            end
            if ($urandom_range(0, 39) == 0) ifc.test_mode = ~ifc.test_mode;
            tick();
            checks++;
            if ({ifc.clk_en, ifc.ready, ifc.sleep} !== {exp_en, exp_rdy, exp_slp}) begin
                fails++;
                $display("FAIL random cyc%0d: en=%b rdy=%b slp=%b required %b %b %b",
                         i, ifc.clk_en, ifc.ready, ifc.sleep, exp_en, exp_rdy, exp_slp);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            mode[d] = M_OFF;
            wake_left[d] = 0;
            idle_run[d] = 0;
        end
        test_reset();
        test_wake_latency();
        test_idle_gating();
        test_sleep_wake();
        test_thr_zero();
        test_fetch_drop();
        test_test_mode();
        ifc.fetch_enable = 2'b11;
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
